chip8_loader: RTL and testbench

//  Program-load controller between the UART receive path and the CHIP-8 interpreter.

---
 rtl/chip8_loader_pkg.sv | 34 +++
 rtl/chip8_loader.sv | 155 +++++++++++++++
 tb/tb_chip8_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_loader_pkg.sv
// Shared types and defaults for the CHIP-8 program loader.
package chip8_loader_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 12'h200;
  localparam int unsigned       MAX_LEN_DEF   = 3584;
  localparam logic [BYTE_W-1:0] SYNC_DEF      = 8'hC8;
  localparam int unsigned       TIMEOUT_DEF   = 25_000_000;
  localparam int unsigned       TO_W_DEF      = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] data;
  } mem_wr_t;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/chip8_loader.sv
// Parses SYNC/LEN/DATA/CSUM frames from the UART byte strobe into interpreter RAM,
// gates the interpreter run flag, and forwards bytes as keypad input while running.
module chip8_loader
  import chip8_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned       MAX_LEN   = MAX_LEN_DEF,
  parameter logic [BYTE_W-1:0] SYNC      = SYNC_DEF,
  parameter int unsigned       TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned       TO_W      = TO_W_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [BYTE_W-1:0] rx_i,
  input  logic              rx_i_v,
  input  logic              reload_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BYTE_W-1:0] mem_data_o,
  output logic              cpu_run_o,
  output logic [BYTE_W-1:0] key_o,
  output logic              key_v_o,
  output logic              load_err_o
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] len_hi_q, len_hi_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  logic [TO_W-1:0]   to_q;
  mem_wr_t           wr_q, wr_d;
  logic              we_q, we_d;
  logic              run_q, run_d;
  logic [BYTE_W-1:0] key_q, key_d;
  logic              key_v_q, key_v_d;
  logic              err_q, err_d;

  logic [LEN_W-1:0]  len_full_c;
  logic              timeout_c;
  logic              sync_c;
  logic              csum_ok_c;

  assign len_full_c = {len_hi_q, rx_i};
  assign sync_c     = rx_i_v && (rx_i == SYNC);
  assign csum_ok_c  = (BYTE_W'(sum_q + rx_i) == '0);
  assign timeout_c  = in_frame(state_q) && !rx_i_v && (to_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_IDLE:   if (sync_c) state_d = ST_LEN_HI;
        ST_LEN_HI: if (rx_i_v) state_d = ST_LEN_LO;
        ST_LEN_LO:
          if (rx_i_v) begin
            if (len_full_c == '0 || len_full_c > LEN_W'(MAX_LEN)) state_d = ST_ERR;
            else                                                  state_d = ST_DATA;
          end
        ST_DATA:   if (rx_i_v && idx_q == len_q - ADDR_W'(1)) state_d = ST_CSUM;
        ST_CSUM:   if (rx_i_v) state_d = csum_ok_c ? ST_RUN : ST_ERR;
        ST_RUN:    if (reload_i) state_d = ST_IDLE;
        ST_ERR:    if (sync_c) state_d = ST_LEN_HI;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    len_hi_d = len_hi_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    wr_d     = wr_q;
    we_d     = 1'b0;
    key_d    = key_q;
    key_v_d  = 1'b0;
    run_d    = (state_d == ST_RUN);
    err_d    = (state_d == ST_ERR) ? 1'b1 : err_q;
    case (state_q)
      ST_IDLE, ST_ERR:
        if (sync_c) begin
          err_d = 1'b0;
          idx_d = '0;
          sum_d = '0;
        end
      ST_LEN_HI: if (rx_i_v) len_hi_d = rx_i;
      ST_LEN_LO: if (rx_i_v) len_d = len_full_c[ADDR_W-1:0];
      ST_DATA:
        if (rx_i_v) begin
          we_d      = 1'b1;
          wr_d.addr = BASE_ADDR + idx_q;
          wr_d.data = rx_i;
          idx_d     = idx_q + ADDR_W'(1);
          sum_d     = BYTE_W'(sum_q + rx_i);
        end
      ST_RUN:
        if (rx_i_v && !reload_i) begin
          key_d   = rx_i;
          key_v_d = 1'b1;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      len_hi_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      wr_q     <= '0;
      we_q     <= 1'b0;
      run_q    <= 1'b0;
      key_q    <= '0;
      key_v_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      wr_q     <= wr_d;
      we_q     <= we_d;
      run_q    <= run_d;
      key_q    <= key_d;
      key_v_q  <= key_v_d;
      err_q    <= err_d;
    end
  end

  // Inter-byte timeout: restarts on every byte and on every state change.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                                 to_q <= '0;
    else if (rx_i_v || state_d != state_q || !in_frame(state_q)) to_q <= '0;
    else                                                         to_q <= to_q + TO_W'(1);
  end

  assign mem_we_o   = we_q;
  assign mem_addr_o = wr_q.addr;
  assign mem_data_o = wr_q.data;
  assign cpu_run_o  = run_q;
  assign key_o      = key_q;
  assign key_v_o    = key_v_q;
  assign load_err_o = err_q;

endmodule

// File: tb/tb_chip8_loader.sv
// Scoreboarded bench for chip8_loader: RAM writes and key bytes are queued as sent and popped as seen.
module tb_chip8_loader;
  import chip8_loader_pkg::*;

  localparam int unsigned TO    = 64;
  localparam logic [7:0]  SYNCB = 8'hC8;

  typedef logic [7:0] byteq_t[$];

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx;
  logic        rx_v;
  logic        reload;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_run;
  logic [7:0]  key;
  logic        key_v;
  logic        load_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          writes_seen = 0;
  mem_wr_t     wq[$];
  logic [7:0]  kq[$];

  always #5 clk = ~clk;

  chip8_loader #(.TIMEOUT(TO), .TO_W(7)) dut (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx), .rx_i_v(rx_v), .reload_i(reload),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .cpu_run_o(cpu_run), .key_o(key), .key_v_o(key_v), .load_err_o(load_err)
  );

  // One clock: scoreboard outputs on the falling edge, then return 1ns after the rising edge.
  task automatic step();
    mem_wr_t    e;
    logic [7:0] k;
    @(negedge clk);
    if (rstn && mem_we) begin
      writes_seen++;
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write got %h=%h, none expected", mem_addr, mem_data);
      end else begin
        e = wq.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          miscompares++;
          $display("FAIL mem_write got %h=%h expected %h=%h", mem_addr, mem_data, e.addr, e.data);
        end
      end
    end
    if (rstn && key_v) begin
      vectors++;
      if (kq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_key got %h", key);
      end else begin
        k = kq.pop_front();
        if (key !== k) begin
          miscompares++;
          $display("FAIL key got %h expected %h", key, k);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx   = b;
    rx_v = 1'b1;
    step();
    rx_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  function automatic logic [7:0] csum_of(input byteq_t d);
    logic [7:0] s = 8'h00;
    foreach (d[i]) s = 8'(s + d[i]);
    return 8'(8'h00 - s);
  endfunction

  task automatic send_frame(input byteq_t d, input logic [7:0] csum);
    logic [15:0] len;
    len = 16'(d.size());
    send_byte(SYNCB);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    foreach (d[i]) begin
      wq.push_back('{addr: 12'(32'h200 + i), data: d[i]});
      send_byte(d[i]);
    end
    send_byte(csum);
    step();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx = '0; rx_v = 1'b0; reload = 1'b0;
    idle(3);
    vectors++;
    if ({mem_we, mem_addr, mem_data, cpu_run, key, key_v, load_err} !== 31'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b expected all zero",
               {mem_we, mem_addr, mem_data, cpu_run, key, key_v, load_err});
    end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_load_ok();
    byteq_t d = '{8'hA1, 8'hB2, 8'hC3};
    send_frame(d, csum_of(d));
    vectors++;
    if ({cpu_run, load_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL load_ok run/err got %b expected 10", {cpu_run, load_err});
    end
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL load_ok_writes pending %0d expected 0", wq.size());
    end
  endtask

  task automatic test_bad_csum();
    byteq_t d  = '{8'hA1, 8'hB2, 8'hC3};
    byteq_t d2 = '{8'h5A, 8'h01};
    pulse_reload();
    vectors++;
    if (cpu_run !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_run got %b expected 0", cpu_run);
    end
    send_frame(d, 8'h00);
    vectors++;
    if ({cpu_run, load_err} !== 2'b01 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL bad_csum run/err got %b pending %0d expected 01 pending 0",
               {cpu_run, load_err}, wq.size());
    end
    send_byte(SYNCB);
    vectors++;
    if (load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_clears_err got %b expected 0", load_err);
    end
    send_byte(8'h00);
    send_byte(8'h02);
    foreach (d2[i]) begin
      wq.push_back('{addr: 12'(32'h200 + i), data: d2[i]});
      send_byte(d2[i]);
    end
    send_byte(csum_of(d2));
    step();
    vectors++;
    if ({cpu_run, load_err} !== 2'b10 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL recover run/err got %b pending %0d expected 10 pending 0",
               {cpu_run, load_err}, wq.size());
    end
  endtask

  task automatic test_bad_len();
    int w0;
    pulse_reload();
    w0 = writes_seen;
    send_byte(SYNCB); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    vectors++;
    if ({cpu_run, load_err} !== 2'b01) begin
      miscompares++;
      $display("FAIL len_zero run/err got %b expected 01", {cpu_run, load_err});
    end
    send_byte(SYNCB); send_byte(8'h0E); send_byte(8'h01);
    idle(3);
    vectors++;
    if ({cpu_run, load_err} !== 2'b01 || writes_seen != w0) begin
      miscompares++;
      $display("FAIL len_over run/err got %b writes %0d expected 01 writes 0",
               {cpu_run, load_err}, writes_seen - w0);
    end
  endtask

  task automatic test_max_len();
    byteq_t d;
    for (int i = 0; i < 3584; i++) d.push_back(8'(i * 7 + 3));
    send_frame(d, csum_of(d));
    idle(2);
    vectors++;
    if ({cpu_run, load_err} !== 2'b10 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL max_len run/err got %b pending %0d expected 10 pending 0",
               {cpu_run, load_err}, wq.size());
    end
    vectors++;
    if (mem_addr !== 12'hFFF) begin
      miscompares++;
      $display("FAIL max_len_last_addr got %h expected fff", mem_addr);
    end
  endtask

  task automatic test_timeout();
    int w0;
    pulse_reload();
    w0 = writes_seen;
    send_byte(SYNCB); send_byte(8'h00); send_byte(8'h02);
    wq.push_back('{addr: 12'h200, data: 8'h11});
    send_byte(8'h11);
    idle(TO - 4);
    vectors++;
    if ({cpu_run, load_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL before_timeout run/err got %b expected 00", {cpu_run, load_err});
    end
    idle(8);
    vectors++;
    if ({cpu_run, load_err} !== 2'b01 || writes_seen - w0 != 1 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL timeout run/err got %b writes %0d expected 01 writes 1",
               {cpu_run, load_err}, writes_seen - w0);
    end
  endtask

  task automatic test_run_keys();
    byteq_t d = '{8'h33};
    send_frame(d, csum_of(d));
    kq.push_back(8'h05);
    send_byte(8'h05);
    kq.push_back(SYNCB);
    send_byte(SYNCB);
    step();
    vectors++;
    if (cpu_run !== 1'b1 || kq.size() != 0) begin
      miscompares++;
      $display("FAIL run_keys run got %b pending %0d expected 1 pending 0", cpu_run, kq.size());
    end
    rx = 8'h77; rx_v = 1'b1; reload = 1'b1;
    step();
    rx_v = 1'b0; reload = 1'b0;
    vectors++;
    if ({cpu_run, key_v} !== 2'b00) begin
      miscompares++;
      $display("FAIL reload_drop run/key_v got %b expected 00", {cpu_run, key_v});
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    int w0;
    byteq_t d = '{8'h9C};
    send_byte(SYNCB); send_byte(8'h00); send_byte(8'h04);
    wq.push_back('{addr: 12'h200, data: 8'h01});
    send_byte(8'h01);
    send_byte(8'h02);
    vectors++;
    if ({mem_we, mem_addr, mem_data} !== {1'b1, 12'h201, 8'h02}) begin
      miscompares++;
      $display("FAIL mid_write got %b/%h/%h expected 1/201/02", mem_we, mem_addr, mem_data);
    end
    rstn = 1'b0;
    #2;
    vectors++;
    if ({mem_we, mem_addr, mem_data, cpu_run, key, key_v, load_err} !== 31'd0) begin
      miscompares++;
      $display("FAIL async_reset got %b expected all zero",
               {mem_we, mem_addr, mem_data, cpu_run, key, key_v, load_err});
    end
    idle(2);
    rstn = 1'b1;
    w0 = writes_seen;
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    idle(2);
    vectors++;
    if (writes_seen != w0 || {cpu_run, load_err} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_ignore writes %0d run/err %b expected 0 and 00",
               writes_seen - w0, {cpu_run, load_err});
    end
    send_frame(d, csum_of(d));
    vectors++;
    if (cpu_run !== 1'b1 || writes_seen - w0 != 1 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL post_reset_load run %b writes %0d expected 1 and 1", cpu_run, writes_seen - w0);
    end
  endtask

  initial begin
    test_reset();
    test_load_ok();
    test_bad_csum();
    test_bad_len();
    test_max_len();
    test_timeout();
    test_run_keys();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
